// File: rtl/conv_result_drain.sv
// Drains N result columns from the N+2 image banks column-major and streams pixels to the host.
// Optional macro DRAIN_CLEAR_EN: strobe o_ClearEn on each host handshake so drained words are zeroed.
module conv_result_drain #(
  parameter int N           = 2,
  parameter int BITS_IMAGEN = 11,
  parameter int BITS_DATA   = BITS_IMAGEN,
  parameter int ADDR_BITS   = 10
) (
  input  logic                          i_CLK,
  input  logic                          i_Rst,
  input  logic                          i_Start,
  input  logic [$clog2(N+2)-1:0]        i_BankBase,
  input  logic [ADDR_BITS-1:0]          i_ColLength,
  input  logic [(N+2)*BITS_IMAGEN-1:0]  i_MemData,
  input  logic                          i_Ready,
  output logic [ADDR_BITS-1:0]          o_ReadAddr,
  output logic                          o_ReadEn,
  output logic [$clog2(N+2)-1:0]        o_MemSelect,
  output logic                          o_ClearEn,
  output logic [BITS_DATA-1:0]          o_Data,
  output logic                          o_Valid,
  output logic                          o_Busy,
  output logic                          o_Done
);

  localparam int SEL_W = $clog2(N+2);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    LATCH,
    SEND,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [ADDR_BITS-1:0]   len_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [SEL_W-1:0]       sel_q;
  logic [BITS_DATA-1:0]   data_q;
  logic [BITS_IMAGEN-1:0] pix;
  logic                   last_addr;
  logic                   last_bank;

  assign last_addr = (addr_q == len_q - ADDR_BITS'(1));
  assign last_bank = (cnt_q == CNT_W'(N-1));

  always_comb begin
    pix = '0;
    for (int unsigned k = 0; k < N+2; k++) begin
      if (sel_q == SEL_W'(k)) pix = i_MemData[k*BITS_IMAGEN +: BITS_IMAGEN];
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_Rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_Start) state_d = (i_ColLength == '0) ? DONE : ISSUE;
      ISSUE:   state_d = LATCH;
      LATCH:   state_d = SEND;
      SEND:    if (i_Ready) state_d = (last_addr && last_bank) ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The bank select advances incrementally with wrap, which equals (base + count) mod (N+2).
  always_ff @(posedge i_CLK) begin
    if (!i_Rst) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      sel_q  <= '0;
      data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_Start) begin
            len_q  <= i_ColLength;
            addr_q <= '0;
            cnt_q  <= '0;
            sel_q  <= i_BankBase;
          end
        end
        LATCH: data_q <= BITS_DATA'(pix);
        SEND: begin
          if (i_Ready && !(last_addr && last_bank)) begin
            if (last_addr) begin
              addr_q <= '0;
              cnt_q  <= cnt_q + CNT_W'(1);
              sel_q  <= (sel_q == SEL_W'(N+1)) ? '0 : sel_q + SEL_W'(1);
            end else begin
              addr_q <= addr_q + ADDR_BITS'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_ReadEn = (state_q == ISSUE);
    o_Valid  = (state_q == SEND);
    o_Busy   = (state_q != IDLE);
    o_Done   = (state_q == DONE);
`ifdef DRAIN_CLEAR_EN
    o_ClearEn = (state_q == SEND) && i_Ready;
`else
    o_ClearEn = 1'b0;
`endif
  end

  assign o_ReadAddr  = addr_q;
  assign o_MemSelect = sel_q;
  assign o_Data      = data_q;

endmodule

// File: tb/tb_conv_result_drain.sv
// Table-driven bench for conv_result_drain with a bank memory model and an output scoreboard.
module tb_conv_result_drain;

  localparam int N  = 2;
  localparam int BI = 11;
  localparam int BD = 11;
  localparam int AB = 4;
  localparam int SW = 2;
  localparam int NB = N + 2;
`ifdef DRAIN_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic            i_CLK, i_Rst, i_Start, i_Ready;
  logic [SW-1:0]   i_BankBase;
  logic [AB-1:0]   i_ColLength;
  logic [NB*BI-1:0] i_MemData;
  logic [AB-1:0]   o_ReadAddr;
  logic            o_ReadEn, o_ClearEn, o_Valid, o_Busy, o_Done;
  logic [SW-1:0]   o_MemSelect;
  logic [BD-1:0]   o_Data;

  conv_result_drain #(.N(N), .BITS_IMAGEN(BI), .BITS_DATA(BD), .ADDR_BITS(AB)) dut (
    .i_CLK(i_CLK), .i_Rst(i_Rst), .i_Start(i_Start), .i_BankBase(i_BankBase),
    .i_ColLength(i_ColLength), .i_MemData(i_MemData), .i_Ready(i_Ready),
    .o_ReadAddr(o_ReadAddr), .o_ReadEn(o_ReadEn), .o_MemSelect(o_MemSelect),
    .o_ClearEn(o_ClearEn), .o_Data(o_Data), .o_Valid(o_Valid), .o_Busy(o_Busy),
    .o_Done(o_Done)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  // Bank memory: bank k address a holds 16k+a, restored on reset, one-cycle read latency.
  logic [BI-1:0] mem [NB][16];
  always @(posedge i_CLK) begin
    if (!i_Rst) begin
      for (int k = 0; k < NB; k++)
        for (int a = 0; a < 16; a++) mem[k][a] <= BI'(16*k + a);
      i_MemData <= '0;
    end else begin
      if (o_ReadEn)
        for (int k = 0; k < NB; k++) i_MemData[k*BI +: BI] <= mem[k][o_ReadAddr];
      if (o_ClearEn) mem[o_MemSelect][o_ReadAddr] <= '0;
    end
  end

  typedef struct {
    int unsigned base, len, stall_word, stall_cyc, poke, exp_done;
  } vec_t;

  typedef struct {
    logic [BD-1:0] data;
    logic [AB-1:0] addr;
    logic [SW-1:0] sel;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int total, bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge i_CLK);
    i_Rst = 1'b0; i_Start = 1'b0; i_Ready = 1'b1;
    repeat (2) @(negedge i_CLK);
    chk("reset_outputs",
        {o_ReadAddr, o_ReadEn, o_MemSelect, o_ClearEn, o_Data, o_Valid, o_Busy, o_Done}, '0);
    i_Rst = 1'b1;
  endtask

  task automatic run_drain(input vec_t v, input bit with_reset);
    int unsigned w, popped, stall_left, rd, clr, done_k, sel;
    if (with_reset) do_reset();
    sb.delete();
    for (int unsigned b = 0; b < N; b++) begin
      sel = (v.base + b) % NB;
      for (int unsigned a = 0; a < v.len; a++)
        sb.push_back('{data: BD'(16*sel + a), addr: AB'(a), sel: SW'(sel)});
    end
    w = N * v.len; popped = 0; stall_left = v.stall_cyc; rd = 0; clr = 0; done_k = 0;
    @(negedge i_CLK);
    chk("idle_before_start", o_Busy, 0);
    i_Start = 1'b1; i_BankBase = SW'(v.base); i_ColLength = AB'(v.len); i_Ready = 1'b1;
    @(posedge i_CLK);
    for (int unsigned k = 1; k <= 400 && done_k == 0; k++) begin
      @(negedge i_CLK);
      if (v.poke != 0 && k == v.poke) begin
        i_Start = 1'b1; i_BankBase = SW'(v.base + 1); i_ColLength = AB'(1);
      end else begin
        i_Start = 1'b0;
      end
      chk("busy", o_Busy, 1);
      if (o_ReadEn) rd++;
      if (o_Done) begin
        done_k = k;
        chk("done_cycle", k, v.exp_done);
        chk("sb_empty_at_done", sb.size(), 0);
      end
      if (o_Valid) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", sb.size(), 1);
        end else begin
          chk("data", o_Data, sb[0].data);
          chk("read_addr", o_ReadAddr, sb[0].addr);
          chk("mem_select", o_MemSelect, sb[0].sel);
          if (popped == v.stall_word && stall_left > 0) begin
            i_Ready = 1'b0; stall_left--;
          end else begin
            i_Ready = 1'b1;
          end
          #1;
          chk("clear_en", o_ClearEn, i_Ready & CLR);
          if (o_ClearEn) clr++;
          if (i_Ready) begin
            void'(sb.pop_front());
            popped++;
          end
        end
      end else begin
        i_Ready = 1'b1;
        #1;
        chk("clear_en_idle", o_ClearEn, 0);
      end
    end
    if (done_k == 0) chk("done_timeout", done_k, v.exp_done);
    chk("read_en_count", rd, w);
    chk("handshakes", popped, w);
    chk("clear_count", clr, CLR ? w : 0);
    @(negedge i_CLK);
    chk("busy_after_done", o_Busy, 0);
    chk("done_pulse_width", o_Done, 0);
    sb.delete();
  endtask

  initial begin
    int unsigned popped;
    total = 0; bad = 0;
    i_Rst = 1'b0; i_Start = 1'b0; i_Ready = 1'b1; i_BankBase = '0; i_ColLength = '0;

    //          base len stall_word stall_cyc poke exp_done
    vecs[0] = '{0,   3,  999,       0,        0,   19};
    vecs[1] = '{0,   3,  1,         5,        0,   24};
    vecs[2] = '{3,   2,  999,       0,        0,   13};
    vecs[3] = '{0,   0,  999,       0,        0,   1};
    vecs[4] = '{1,   1,  999,       0,        5,   7};
    vecs[5] = '{2,   4,  7,         2,        0,   27};
    vecs[6] = '{3,   15, 999,       0,        0,   91};

    for (int i = 0; i < 7; i++) run_drain(vecs[i], 1'b1);

    // Reset asserted while word 4 is presented, then a fresh start must begin at addr 0.
    do_reset();
    popped = 0;
    @(negedge i_CLK);
    i_Start = 1'b1; i_BankBase = '0; i_ColLength = AB'(3); i_Ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge i_CLK);
      i_Start = 1'b0;
      if (o_Valid) begin
        if (popped == 3) break;
        popped++;
      end
    end
    chk("reached_word4", popped, 3);
    i_Rst = 1'b0;
    @(negedge i_CLK);
    chk("midreset_outputs",
        {o_ReadAddr, o_ReadEn, o_MemSelect, o_ClearEn, o_Data, o_Valid, o_Busy, o_Done}, '0);
    i_Rst = 1'b1;
    run_drain(vecs[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
